vga_sync_gen: RTL
=================

# vga_sync_gen

Video timing generator for the 800x600@72Hz mode, clocked by the 50.0 MHz pixel clock from the on-chip PLL stage. Free-running horizontal and vertical counters produce registered hsync/vsync, an active-video flag, the current pixel coordinates and line/frame start strobes. The pong renderer consumes these signals, and they also drive the VGA connector pins. Timing values are parameters so the same block serves other modes.

## Interface

Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync pulse width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_VISIBLE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- H_POL, 1, hsync active level (1 = active high)
- V_POL, 1, vsync active level (1 = active high)

Ports:
- px_clk  in  1  pixel clock (50.0 MHz); the only clock
- reset  in  1  reset, synchronous to px_clk, active-high
- hsync  out  1  horizontal sync at H_POL polarity
- vsync  out  1  vertical sync at V_POL polarity
- activevideo  out  1  high while (x_px, y_px) is inside the visible area
- x_px  out  11  horizontal counter value, 0..H_TOTAL-1
- y_px  out  10  vertical counter value, 0..V_TOTAL-1
- line_start  out  1  one-cycle strobe when x_px == 0
- frame_start  out  1  one-cycle strobe when x_px == 0 and y_px == 0

## Operation

- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 1040). V_TOTAL likewise (default 666).
- Parameter constraint: H_TOTAL ≤ 2048 and V_TOTAL ≤ 1024. Out-of-range values are unsupported.
- Internal counters hc (11 bit) and vc (10 bit) are registered.
- hc increments every px_clk cycle. At hc == H_TOTAL-1 it wraps to 0 and vc advances.
- vc wraps from V_TOTAL-1 to 0 on the same edge that hc wraps.
- Output stage is registered. Each cycle, all outputs are decoded from the current (hc, vc):
  - x_px ← hc, y_px ← vc
  - activevideo ← (hc < H_VISIBLE) && (vc < V_VISIBLE)
  - hsync ← H_POL when H_VISIBLE+H_FP ≤ hc < H_VISIBLE+H_FP+H_SYNC, else ~H_POL
  - vsync ← V_POL when V_VISIBLE+V_FP ≤ vc < V_VISIBLE+V_FP+V_SYNC, else ~V_POL
  - line_start ← (hc == 0); frame_start ← (hc == 0 && vc == 0)
- All outputs are mutually aligned: every output in a given cycle describes the same (x_px, y_px).
- vsync edges coincide with x_px == 0 (line boundary). They are never mid-line.
- No enable or stall input: the block free-runs continuously.

## Timing

- Reset (sampled high at a px_clk edge):
  - hc = 0, vc = 0
  - x_px = 0, y_px = 0
  - activevideo = 0, line_start = 0, frame_start = 0
  - hsync = ~H_POL, vsync = ~V_POL
- First edge with reset low: counters become (1,0). Outputs present (0,0): activevideo = 1, line_start = 1, frame_start = 1.
- Latency: outputs lag the internal counters by exactly 1 cycle.
- Output sequence is periodic from the first post-reset edge:
  - line period = H_TOTAL cycles (1040)
  - frame period = H_TOTAL·V_TOTAL cycles (692640 at 50 MHz ≈ 72.19 Hz)
- Wrap boundaries:
  - x_px == 1039 is followed by x_px == 0 with y_px + 1
  - (1039, 665) is followed by (0, 0) with frame_start = 1
- Reset asserted mid-frame: the next edge forces the reset values regardless of counter state. Timing restarts as from power-up with no partial-line artifacts.

## Test plan

- Reset held 5 cycles, then released:
  - during reset, all outputs hold their reset values (hsync = vsync = 0 with default polarity)
  - first post-reset cycle shows x_px = 0, y_px = 0, activevideo = 1, frame_start = 1
- Line 0 horizontal timing:
  - activevideo high for x_px 0..799, low for 800..1039
  - hsync high exactly for x_px 856..975 (120 cycles)
  - line_start pulses every 1040 cycles
- Vertical timing over one full frame:
  - activevideo never high for y_px ≥ 600
  - vsync high for y_px 637..642 (6240 cycles), rising and falling at x_px == 0
  - frame_start period = 692640 cycles
- Wrap check:
  - (1039, 665) → (0, 0); (1039, 10) → (0, 11)
  - y_px never reaches 666; x_px never reaches 1040
- Mid-frame reset at (400, 300), asserted for 1 cycle: next cycle outputs the reset values, and the following cycle shows (0, 0) with frame_start = 1.
- Small-mode override (H 8/2/3/3, V 4/1/2/1, H_POL = V_POL = 0):
  - line = 16 cycles, frame = 128 cycles
  - hsync low for x_px 10..12; vsync low for y_px 5..6
  - activevideo for x < 8, y < 4

Source files
------------

// File: rtl/vga_sync_gen.sv
// Video timing generator: free-running pixel/line counters with a registered,
// mutually aligned decode stage for sync, active-video, coordinates and strobes.
module vga_sync_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FP      = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BP      = 64,
    parameter int V_VISIBLE = 600,
    parameter int V_FP      = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 23,
    parameter bit H_POL     = 1'b1,
    parameter bit V_POL     = 1'b1
) (
    input  logic        px_clk,
    input  logic        reset,
    output logic        hsync,
    output logic        vsync,
    output logic        activevideo,
    output logic [10:0] x_px,
    output logic [9:0]  y_px,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // One extra bit so a boundary equal to the full range (2048 / 1024) still compares correctly.
    localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_END   = 12'(H_VISIBLE);
    localparam logic [11:0] H_SYNC_BEG  = 12'(H_VISIBLE + H_FP);
    localparam logic [11:0] H_SYNC_END  = 12'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_END   = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_END  = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [10:0] hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic [11:0] hc_ext;
    logic [10:0] vc_ext;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        active_q, active_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        line_q, line_d;
    logic        frame_q, frame_d;

    assign hc_ext = {1'b0, hc_q};
    assign vc_ext = {1'b0, vc_q};

    always_comb begin
        hc_d = hc_q + 11'd1;
        vc_d = vc_q;
        if (hc_ext == H_LAST) begin
            hc_d = '0;
            if (vc_ext == V_LAST) begin
                vc_d = '0;
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end
    end

    // Decode stage: everything derives from the same (hc, vc), so outputs stay aligned.
    always_comb begin
        x_d      = hc_q;
        y_d      = vc_q;
        active_d = (hc_ext < H_ACT_END) && (vc_ext < V_ACT_END);
        hsync_d  = ((hc_ext >= H_SYNC_BEG) && (hc_ext < H_SYNC_END)) ? H_POL : ~H_POL;
        vsync_d  = ((vc_ext >= V_SYNC_BEG) && (vc_ext < V_SYNC_END)) ? V_POL : ~V_POL;
        line_d   = (hc_q == 11'd0);
        frame_d  = (hc_q == 11'd0) && (vc_q == 10'd0);
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            hc_q     <= '0;
            vc_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            active_q <= 1'b0;
            hsync_q  <= ~H_POL;
            vsync_q  <= ~V_POL;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            active_q <= active_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign activevideo = active_q;
    assign x_px        = x_q;
    assign y_px        = y_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule
